button_input_encoder: RTL and testbench

Front-end stage directly upstream of fsm_controller and comparator in the Genius game. Synchronises and debounces four raw colour push-buttons, then encodes one accepted press into the 2-bit player_input code. Emits a single-cycle input_ready pulse per press. Flags illegal multi-button presses and suppresses presses made while the controller is not accepting input.

---
 rtl/genius_pkg.sv | 35 +++
 rtl/button_debounce.sv | 54 +++++
 rtl/button_input_encoder.sv | 118 +++++++++++
 tb/tb_button_input_encoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius game input path.
package genius_pkg;

   typedef logic [1:0] color_t;

   localparam color_t COLOR_GREEN  = 2'd0;
   localparam color_t COLOR_RED    = 2'd1;
   localparam color_t COLOR_YELLOW = 2'd2;
   localparam color_t COLOR_BLUE   = 2'd3;

   localparam int unsigned NUM_COLORS = 4;

   typedef enum logic {IDLE, HELD} enc_state_t;

   // Colour code of the lowest set button; only meaningful when exactly one bit is set.
   function automatic color_t encode_color(input logic [NUM_COLORS-1:0] btn);
      color_t code;
      code = COLOR_GREEN;
      for (int i = NUM_COLORS - 1; i >= 0; i--) begin
         if (btn[i]) code = color_t'(i);
      end
      return code;
   endfunction

   // Number of buttons currently pressed.
   function automatic logic [2:0] count_pressed(input logic [NUM_COLORS-1:0] btn);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < NUM_COLORS; i++) begin
         n = n + 3'(btn[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// One-bit synchroniser followed by a counter-based debouncer.
module button_debounce #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw_i,
   output logic stable_o
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   stable_q, stable_d;
   logic                   sync_bit;

   assign sync_bit = sync_q[SYNC_STAGES-1];

   // Shift the raw level through the synchroniser chain.
   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw_i};
   end

   // Count consecutive disagreeing cycles; flip the stable level after a full run.
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (sync_bit == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
         stable_d = ~stable_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Debounce state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable_o = stable_q;

endmodule

// File: rtl/button_input_encoder.sv
// Debounces four colour buttons and encodes one accepted press per full release.
// Optional inactivity timeout enabled by defining GENIUS_INPUT_TIMEOUT_EN.
module button_input_encoder
   import genius_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_COLORS-1:0] btn_raw,
   input  logic                  enable,
   output color_t                player_input,
   output logic                  input_ready,
   output logic                  multi_press_err,
   output logic [NUM_COLORS-1:0] btn_led,
   output logic                  timeout
);

   if (DEBOUNCE_CYCLES < 2 || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("button_input_encoder: illegal parameter values");
   end

   logic [NUM_COLORS-1:0] stable;
   logic [2:0]            n_pressed;
   color_t                press_code;

   enc_state_t state_q;
   color_t     player_input_q;
   logic       input_ready_q;
   logic       multi_press_err_q;

   for (genvar i = 0; i < NUM_COLORS; i++) begin : g_deb
      button_debounce #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk      (clk),
         .rst      (rst),
         .btn_raw_i(btn_raw[i]),
         .stable_o (stable[i])
      );
   end

   // Classify the debounced button set.
   always_comb begin
      n_pressed  = count_pressed(stable);
      press_code = encode_color(stable);
   end

   // Accept at most one press per full release; stale or multi presses are consumed in HELD.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= IDLE;
         player_input_q    <= COLOR_GREEN;
         input_ready_q     <= 1'b0;
         multi_press_err_q <= 1'b0;
      end else begin
         input_ready_q     <= 1'b0;
         multi_press_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (stable != '0) begin
                  state_q <= HELD;
                  if (enable) begin
                     if (n_pressed == 3'd1) begin
                        player_input_q <= press_code;
                        input_ready_q  <= 1'b1;
                     end else begin
                        multi_press_err_q <= 1'b1;
                     end
                  end
               end
            end
            HELD: begin
               if (stable == '0) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign player_input    = player_input_q;
   assign input_ready     = input_ready_q;
   assign multi_press_err = multi_press_err_q;
   assign btn_led         = stable;

`ifdef GENIUS_INPUT_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TW-1:0] to_cnt_q;
   logic          timeout_q;

   // Count idle cycles while the controller waits; any press or disable restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         if (state_q != IDLE || !enable || stable != '0) begin
            to_cnt_q <= '0;
         end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b1;
         end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
         end
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_button_input_encoder.sv
// Scoreboard bench for button_input_encoder with small debounce/timeout parameters.
module tb_button_input_encoder;

   localparam int unsigned DEB = 4;
   localparam int unsigned SYN = 2;
   localparam int unsigned TMO = 20;
   localparam int          LAT = SYN + DEB + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] btn_raw = 4'b0000;
   logic       enable = 1'b0;
   logic [1:0] player_input;
   logic       input_ready;
   logic       multi_press_err;
   logic [3:0] btn_led;
   logic       timeout;

   button_input_encoder #(
      .DEBOUNCE_CYCLES(DEB),
      .SYNC_STAGES    (SYN),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .btn_raw        (btn_raw),
      .enable         (enable),
      .player_input   (player_input),
      .input_ready    (input_ready),
      .multi_press_err(multi_press_err),
      .btn_led        (btn_led),
      .timeout        (timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         is_err;
      logic [1:0] code;
      int         at;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every pulse must match the oldest expected event.
   always @(negedge clk) begin
      if (!rst && (input_ready || multi_press_err)) begin
         chk("exclusive", {31'd0, input_ready & multi_press_err}, 32'd0);
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pulse: actual ready=%0b err=%0b at cycle %0d required none",
                     input_ready, multi_press_err, cyc);
         end else begin
            e = sb.pop_front();
            chk("pulse_kind", {31'd0, multi_press_err}, {31'd0, e.is_err});
            chk("pulse_cycle", cyc, e.at);
            chk("player_input", {30'd0, player_input}, {30'd0, e.code});
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [3:0] b, input bit exp_pulse, input bit is_err,
                        input logic [1:0] code);
      btn_raw = b;
      if (exp_pulse) sb.push_back('{is_err, code, cyc + LAT});
      tick(10);
      chk("led_hold", {28'd0, btn_led}, {28'd0, b});
      btn_raw = 4'b0000;
      tick(12);
      chk("led_release", {28'd0, btn_led}, 32'd0);
   endtask

   task automatic drained(input string name);
      chk(name, sb.size(), 32'd0);
   endtask

   logic [3:0] led_seen;
   int         hits[$];
   int         r;

   initial begin
      // Reset state
      tick(3);
      chk("rst_player_input", {30'd0, player_input}, 32'd0);
      chk("rst_ready", {31'd0, input_ready}, 32'd0);
      chk("rst_err", {31'd0, multi_press_err}, 32'd0);
      chk("rst_led", {28'd0, btn_led}, 32'd0);
      chk("rst_timeout", {31'd0, timeout}, 32'd0);
      rst = 1'b0;
      tick(2);

      // Single press of colour 2
      enable = 1'b1;
      press(4'b0100, 1'b1, 1'b0, 2'd2);
      enable = 1'b0;
      drained("single_drain");
      chk("single_hold_value", {30'd0, player_input}, 32'd2);

      // Glitch of DEB-1 cycles is rejected
      enable   = 1'b1;
      led_seen = 4'b0000;
      btn_raw  = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         led_seen = led_seen | btn_led;
      end
      btn_raw = 4'b0000;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         led_seen = led_seen | btn_led;
      end
      enable = 1'b0;
      chk("glitch_led", {28'd0, led_seen}, 32'd0);
      drained("glitch_drain");

      // Multi-press flags error, keeps colour 2; then colour 3
      enable = 1'b1;
      press(4'b1001, 1'b1, 1'b1, 2'd2);
      press(4'b1000, 1'b1, 1'b0, 2'd3);
      enable = 1'b0;
      drained("multi_drain");

      // Press made while disabled is never accepted
      btn_raw = 4'b0010;
      tick(10);
      enable = 1'b1;
      tick(5);
      chk("disabled_led", {28'd0, btn_led}, 32'd2);
      btn_raw = 4'b0000;
      tick(12);
      press(4'b0010, 1'b1, 1'b0, 2'd1);
      enable = 1'b0;
      drained("disabled_drain");

      // Reset in the middle of a debounced, held press
      enable  = 1'b1;
      btn_raw = 4'b0001;
      sb.push_back('{1'b0, 2'd0, cyc + LAT});
      tick(10);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("midrst_player_input", {30'd0, player_input}, 32'd0);
      chk("midrst_led", {28'd0, btn_led}, 32'd0);
      chk("midrst_ready", {31'd0, input_ready}, 32'd0);
      chk("midrst_err", {31'd0, multi_press_err}, 32'd0);
      sb.push_back('{1'b0, 2'd0, cyc + LAT});
      tick(10);
      btn_raw = 4'b0000;
      tick(12);
      enable = 1'b0;
      drained("midrst_drain");

      // Inactivity timeout
      rst = 1'b1;
      tick(1);
      rst    = 1'b0;
      enable = 1'b1;
      r      = cyc;
      for (int i = 0; i < 45; i++) begin
         tick(1);
         if (timeout) hits.push_back(cyc - r);
      end
      enable = 1'b0;
`ifdef GENIUS_INPUT_TIMEOUT_EN
      chk("timeout_count", hits.size(), 32'd2);
      chk("timeout_first", (hits.size() > 0) ? hits[0] : -1, 32'd20);
      chk("timeout_second", (hits.size() > 1) ? hits[1] : -1, 32'd40);
`else
      chk("timeout_count", hits.size(), 32'd0);
`endif
      drained("final_drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
